// File: rtl/beeb_bus_responder.sv
// Beeb motherboard-side 6502 bus responder: Phi0 generation, RAM, 1MHz stretch, Rdy waits.
// Optional TIMER_IRQ_EN adds a 16-bit cycle down-counter with IRQ at &FE60-&FE62.
module beeb_bus_responder #(
  parameter int         HALF_PERIOD = 20,
  parameter int         MEM_AW      = 16,
  parameter logic [7:0] IO_LO       = 8'hFC,
  parameter logic [7:0] IO_HI       = 8'hFE,
  parameter logic [7:0] WAIT_PAGE   = 8'hFD,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        Res_n,
  output logic        Phi0,
  input  logic [15:0] Addr,
  input  logic        R_W_n,
  input  logic [7:0]  Data_in,
  output logic [7:0]  Data_out,
  output logic        Data_oe,
  output logic        Rdy,
  output logic        IRQ_n,
  output logic [31:0] cycle_count
);

  localparam int PW = $clog2(3 * HALF_PERIOD);

  typedef enum logic {PHI1, PHI2} state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [PW-1:0]   r_phase;
  logic [PW-1:0]   w_phase_nx;
  logic [PW-1:0]   w_last_idx;
  logic            w_last;
  logic            w_p1_end;
  logic            w_p2_end;

  logic [15:0]     r_addr;
  logic            r_rw;
  logic            r_stretch;
  logic [7:0]      r_dout;
  logic [31:0]     r_cycles;
  logic            r_rdy;
  logic [7:0]      r_wait;

  logic [7:0]      w_page;
  logic            w_io;
  logic [7:0]      w_rdata;
  logic            w_we;

  logic [7:0]      r_mem [0:(1<<MEM_AW)-1];

  assign w_page     = Addr[15:8];
  assign w_io       = (w_page >= IO_LO) && (w_page <= IO_HI);
  assign w_last_idx = (r_state == PHI2 && r_stretch)
                    ? PW'(3 * HALF_PERIOD - 1)
                    : PW'(HALF_PERIOD - 1);
  assign w_last     = (r_phase == w_last_idx);
  assign w_p1_end   = (r_state == PHI1) && w_last;
  assign w_p2_end   = (r_state == PHI2) && w_last;
  assign w_we       = w_p2_end && !r_rw;

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase + 1'b1;
    unique case (1'b1)
      w_p1_end: begin
        w_state_nx = PHI2;
        w_phase_nx = '0;
      end
      w_p2_end: begin
        w_state_nx = PHI1;
        w_phase_nx = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) begin
      r_state <= PHI1;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
    end
  end

  // Commit only on the closing edge so an aborted cycle leaves RAM untouched.
  always_ff @(posedge clock) begin
    if (w_we)
      r_mem[r_addr[MEM_AW-1:0]] <= Data_in;
  end

`ifdef TIMER_IRQ_EN
  logic [15:0] r_tcnt;
  logic [7:0]  r_tlat;
  logic        r_armed;
  logic        r_irq_n;

  always_comb begin
    unique case (1'b1)
      (Addr == 16'hFE60): w_rdata = r_tcnt[7:0];
      (Addr == 16'hFE61): w_rdata = r_tcnt[15:8];
      (Addr == 16'hFE62): w_rdata = {~r_irq_n, r_armed, 6'b0};
      default:            w_rdata = r_mem[Addr[MEM_AW-1:0]];
    endcase
  end

  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) begin
      r_tcnt  <= '0;
      r_tlat  <= '0;
      r_armed <= 1'b0;
      r_irq_n <= 1'b1;
    end else if (w_p2_end) begin
      if (w_we && r_addr == 16'hFE60)
        r_tlat <= Data_in;
      if (w_we && r_addr == 16'hFE61) begin
        r_tcnt  <= {Data_in, r_tlat};
        r_armed <= 1'b1;
      end else if (r_armed) begin
        // A load of 0 or 1 both fire at the next cycle end.
        if (r_tcnt <= 16'd1) begin
          r_tcnt  <= '0;
          r_armed <= 1'b0;
          r_irq_n <= 1'b0;
        end else begin
          r_tcnt <= r_tcnt - 16'd1;
        end
      end
      if (w_we && r_addr == 16'hFE62)
        r_irq_n <= 1'b1;
    end
  end

  assign IRQ_n = r_irq_n;
`else
  assign w_rdata = r_mem[Addr[MEM_AW-1:0]];
  assign IRQ_n   = 1'b1;
`endif

  always_ff @(posedge clock or negedge Res_n) begin
    if (!Res_n) begin
      r_addr    <= '0;
      r_rw      <= 1'b1;
      r_stretch <= 1'b0;
      r_dout    <= '0;
      r_cycles  <= '0;
      r_rdy     <= 1'b1;
      r_wait    <= '0;
    end else begin
      if (w_p1_end) begin
        r_addr    <= Addr;
        r_rw      <= R_W_n;
        r_stretch <= w_io;
        if (R_W_n)
          r_dout <= w_rdata;
        // Release takes priority; a wait-page hit while waiting is ignored.
        if (!r_rdy) begin
          if (r_wait == 8'd0)
            r_rdy <= 1'b1;
        end else if (w_page == WAIT_PAGE) begin
          r_rdy  <= 1'b0;
          r_wait <= 8'(WAIT_CYCLES);
        end
      end
      if (w_p2_end) begin
        r_cycles <= r_cycles + 32'd1;
        if (!r_rdy && r_wait != 8'd0)
          r_wait <= r_wait - 8'd1;
      end
    end
  end

  assign Phi0        = (r_state == PHI2);
  assign Data_oe     = (r_state == PHI2) && r_rw;
  assign Data_out    = r_dout;
  assign Rdy         = r_rdy;
  assign cycle_count = r_cycles;

endmodule

// File: tb/tb_beeb_bus_responder.sv
// Directed bench for beeb_bus_responder at HALF_PERIOD=20.
// Timer checks follow TIMER_IRQ_EN; without it &FE60-&FE62 are checked as RAM.
module tb_beeb_bus_responder;

  logic        clock   = 1'b0;
  logic        Res_n   = 1'b1;
  logic [15:0] Addr    = 16'h0000;
  logic        R_W_n   = 1'b1;
  logic [7:0]  Data_in = 8'h00;
  logic        Phi0;
  logic [7:0]  Data_out;
  logic        Data_oe;
  logic        Rdy;
  logic        IRQ_n;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  int          lo, hi, oe;
  logic [7:0]  q;
  logic        rlo, rhi;
  logic [31:0] cc0;

  always #5 clock = ~clock;

  beeb_bus_responder dut (
    .clock       (clock),
    .Res_n       (Res_n),
    .Phi0        (Phi0),
    .Addr        (Addr),
    .R_W_n       (R_W_n),
    .Data_in     (Data_in),
    .Data_out    (Data_out),
    .Data_oe     (Data_oe),
    .Rdy         (Rdy),
    .IRQ_n       (IRQ_n),
    .cycle_count (cycle_count)
  );

  // Runs one bus cycle from the first PHI1 sample; ends on the first PHI1 sample of the next.
  task automatic bus_cycle(input logic [15:0] a, input logic rw,
                           input logic [7:0] d, input logic [15:0] a2);
    Addr    = a;
    R_W_n   = rw;
    Data_in = d;
    lo  = 0;
    hi  = 0;
    oe  = 0;
    q   = 8'hxx;
    rlo = Rdy;
    rhi = 1'bx;
    while (Phi0 === 1'b0 && lo < 400) begin
      lo++;
      if (Data_oe === 1'b1) oe++;
      @(negedge clock);
    end
    Addr = a2;
    rhi  = Rdy;
    while (Phi0 === 1'b1 && hi < 400) begin
      hi++;
      if (Data_oe === 1'b1) oe++;
      q = Data_out;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    #2 Res_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (Phi0 !== 1'b0) begin
      errors++; $display("FAIL reset_phi0: got %b want 0", Phi0);
    end
    checks++;
    if (Data_oe !== 1'b0) begin
      errors++; $display("FAIL reset_oe: got %b want 0", Data_oe);
    end
    checks++;
    if (Data_out !== 8'h00) begin
      errors++; $display("FAIL reset_dout: got %h want 00", Data_out);
    end
    checks++;
    if (Rdy !== 1'b1) begin
      errors++; $display("FAIL reset_rdy: got %b want 1", Rdy);
    end
    checks++;
    if (IRQ_n !== 1'b1) begin
      errors++; $display("FAIL reset_irq: got %b want 1", IRQ_n);
    end
    checks++;
    if (cycle_count !== 32'd0) begin
      errors++; $display("FAIL reset_count: got %0d want 0", cycle_count);
    end
    Res_n = 1'b1;
  endtask

  task automatic test_phi0_timing();
    bus_cycle(16'h0000, 1'b1, 8'h00, 16'h0000);
    checks++;
    if (lo !== 20) begin
      errors++; $display("FAIL phi1_len: got %0d want 20", lo);
    end
    checks++;
    if (hi !== 20) begin
      errors++; $display("FAIL phi2_len: got %0d want 20", hi);
    end
    checks++;
    if (cycle_count !== 32'd1) begin
      errors++; $display("FAIL count_1: got %0d want 1", cycle_count);
    end
    repeat (3) bus_cycle(16'h0000, 1'b1, 8'h00, 16'h0000);
    checks++;
    if (cycle_count !== 32'd4) begin
      errors++; $display("FAIL count_4: got %0d want 4", cycle_count);
    end
  endtask

  task automatic test_read_write();
    bus_cycle(16'h2000, 1'b0, 8'hA5, 16'h2000);
    checks++;
    if (oe !== 0) begin
      errors++; $display("FAIL write_oe: got %0d clocks want 0", oe);
    end
    bus_cycle(16'h2001, 1'b0, 8'h3C, 16'h2001);
    bus_cycle(16'h2000, 1'b1, 8'h00, 16'h2000);
    checks++;
    if (q !== 8'hA5) begin
      errors++; $display("FAIL read_2000: got %h want a5", q);
    end
    checks++;
    if (oe !== 20) begin
      errors++; $display("FAIL read_oe: got %0d clocks want 20", oe);
    end
    bus_cycle(16'h2001, 1'b1, 8'h00, 16'h2001);
    checks++;
    if (q !== 8'h3C) begin
      errors++; $display("FAIL read_2001: got %h want 3c", q);
    end
  endtask

  task automatic test_stretch();
    logic [15:0] addrs [6];
    int          exp_hi [6];
    addrs  = '{16'hFE40, 16'h2000, 16'hFC00, 16'hFBFF, 16'hFEFF, 16'hFF00};
    exp_hi = '{60, 20, 60, 20, 60, 20};
    for (int i = 0; i < 6; i++) begin
      cc0 = cycle_count;
      bus_cycle(addrs[i], 1'b1, 8'h00, addrs[i]);
      checks++;
      if (hi !== exp_hi[i] || lo !== 20) begin
        errors++;
        $display("FAIL stretch_%h: got lo %0d hi %0d want lo 20 hi %0d",
                 addrs[i], lo, hi, exp_hi[i]);
      end
      checks++;
      if (cycle_count !== cc0 + 32'd1) begin
        errors++;
        $display("FAIL stretch_count_%h: got %0d want %0d", addrs[i], cycle_count, cc0 + 32'd1);
      end
    end
  endtask

  task automatic test_addr_change();
    bus_cycle(16'h2200, 1'b0, 8'h22, 16'h2200);
    bus_cycle(16'h2100, 1'b0, 8'h11, 16'h2200);
    bus_cycle(16'h2200, 1'b1, 8'h00, 16'h2200);
    checks++;
    if (q !== 8'h22) begin
      errors++; $display("FAIL addr_change_2200: got %h want 22", q);
    end
    bus_cycle(16'h2100, 1'b1, 8'h00, 16'h2100);
    checks++;
    if (q !== 8'h11) begin
      errors++; $display("FAIL addr_change_2100: got %h want 11", q);
    end
  endtask

  task automatic test_wait();
    bus_cycle(16'hFD00, 1'b1, 8'h00, 16'hFD00);
    checks++;
    if (rlo !== 1'b1 || rhi !== 1'b0 || hi !== 60) begin
      errors++; $display("FAIL wait_a: got rdy %b/%b hi %0d want 1/0 hi 60", rlo, rhi, hi);
    end
    bus_cycle(16'hFD10, 1'b0, 8'h77, 16'hFD10);
    checks++;
    if (rhi !== 1'b0) begin
      errors++; $display("FAIL wait_b: got rdy %b want 0", rhi);
    end
    bus_cycle(16'h2000, 1'b1, 8'h00, 16'h2000);
    checks++;
    if (rhi !== 1'b1 || q !== 8'hA5) begin
      errors++; $display("FAIL wait_c: got rdy %b data %h want 1 a5", rhi, q);
    end
    bus_cycle(16'hFD10, 1'b1, 8'h00, 16'hFD10);
    checks++;
    if (rhi !== 1'b0 || q !== 8'h77) begin
      errors++; $display("FAIL wait_d: got rdy %b data %h want 0 77", rhi, q);
    end
    bus_cycle(16'h2000, 1'b1, 8'h00, 16'h2000);
    checks++;
    if (rhi !== 1'b0 || q !== 8'hA5) begin
      errors++; $display("FAIL wait_e: got rdy %b data %h want 0 a5", rhi, q);
    end
    bus_cycle(16'h0000, 1'b1, 8'h00, 16'h0000);
    checks++;
    if (rhi !== 1'b1) begin
      errors++; $display("FAIL wait_f: got rdy %b want 1", rhi);
    end
  endtask

  task automatic test_timer();
    bus_cycle(16'hFE60, 1'b0, 8'h03, 16'hFE60);
    bus_cycle(16'hFE61, 1'b0, 8'h00, 16'hFE61);
`ifdef TIMER_IRQ_EN
    for (int i = 1; i <= 3; i++) begin
      bus_cycle(16'h0000, 1'b1, 8'h00, 16'h0000);
      checks++;
      if (IRQ_n !== (i == 3 ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL timer_cycle%0d: got irq_n %b want %b", i, IRQ_n, (i != 3));
      end
    end
    bus_cycle(16'hFE62, 1'b1, 8'h00, 16'hFE62);
    checks++;
    if (q !== 8'h80) begin
      errors++; $display("FAIL timer_status: got %h want 80", q);
    end
    bus_cycle(16'hFE62, 1'b0, 8'h00, 16'hFE62);
    checks++;
    if (IRQ_n !== 1'b1) begin
      errors++; $display("FAIL timer_ack: got irq_n %b want 1", IRQ_n);
    end
`else
    bus_cycle(16'hFE60, 1'b1, 8'h00, 16'hFE60);
    checks++;
    if (q !== 8'h03 || hi !== 60) begin
      errors++; $display("FAIL fe60_ram: got %h hi %0d want 03 hi 60", q, hi);
    end
    repeat (4) bus_cycle(16'h0000, 1'b1, 8'h00, 16'h0000);
    checks++;
    if (IRQ_n !== 1'b1) begin
      errors++; $display("FAIL irq_tied: got %b want 1", IRQ_n);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int n;
    bus_cycle(16'h3000, 1'b0, 8'h00, 16'h3000);
    bus_cycle(16'h2000, 1'b1, 8'h00, 16'h2000);
    Addr    = 16'h3000;
    R_W_n   = 1'b0;
    Data_in = 8'h5A;
    n = 0;
    while (Phi0 !== 1'b1 && n < 400) begin
      n++;
      @(negedge clock);
    end
    repeat (5) @(negedge clock);
    Res_n = 1'b0;
    #1;
    checks++;
    if (Phi0 !== 1'b0 || Rdy !== 1'b1 || Data_oe !== 1'b0) begin
      errors++; $display("FAIL midreset_ctl: got phi0 %b rdy %b oe %b want 0 1 0", Phi0, Rdy, Data_oe);
    end
    checks++;
    if (Data_out !== 8'h00 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL midreset_out: got dout %h count %0d want 00 0", Data_out, cycle_count);
    end
    @(negedge clock);
    Res_n = 1'b1;
    bus_cycle(16'h3000, 1'b1, 8'h00, 16'h3000);
    checks++;
    if (q !== 8'h00 || lo !== 20) begin
      errors++; $display("FAIL midreset_ram: got %h lo %0d want 00 lo 20", q, lo);
    end
  endtask

  initial begin
    test_reset();
    test_phi0_timing();
    test_read_write();
    test_stretch();
    test_addr_change();
    test_wait();
    test_timer();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
